// File: rtl/gray_disp_pkg.sv
// Shared types and helpers for the Gray/BCD display driver.
//   bcd_state_t : BCD engine FSM states (IDLE, SHIFT, DONE)
//   SEG_BLANK   : all segments off (active-low)
//   seg7()      : BCD nibble -> active-low {g,f,e,d,c,b,a} pattern, blank for codes > 9
//   gray2bin()  : Gray -> binary for a word of width w (w <= 16), bits >= w ignored
//   digits_fit(): true when DIGITS decimal digits can hold 2^GRAY_W-1
package gray_disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // Binary bit i is the XOR of all Gray bits from i upwards; the log-step
    // shift/XOR ladder builds that suffix parity for every bit at once.
    function automatic logic [15:0] gray2bin(input logic [15:0] g, input int w);
        logic [15:0] b;
        b = g;
        for (int i = 0; i < 16; i++) begin
            if (i >= w) b[i] = 1'b0;
        end
        for (int s = 1; s < 16; s = s * 2) begin
            b = b ^ (b >> s);
        end
        return b;
    endfunction

    function automatic bit digits_fit(input int gray_w, input int digits);
        logic [63:0] p10;
        p10 = 64'd1;
        for (int i = 0; i < digits && i < 19; i++) begin
            p10 = p10 * 64'd10;
        end
        return p10 > ((64'd1 << gray_w) - 64'd1);
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary -> BCD converter.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : conversion request, bin is sampled when it is taken
//   bin        : binary value to convert
//   busy       : high from the load of a value until its result has been offered
//   done       : high for the single cycle the result on bcd is final (state DONE)
//   bcd        : DIGITS packed BCD nibbles, digit 0 in the low nibble
//   state      : current FSM state
//
// Handshake: start behaves as valid, and the engine is ready whenever it is
// not in SHIFT (IDLE or DONE). A request is taken on a clock edge where start=1
// and state!=SHIFT; the requester must hold start until then. A request taken
// in DONE restarts immediately, so back-to-back conversions need no IDLE cycle.
module bin2bcd_seq
    import gray_disp_pkg::*;
#(
    parameter int GRAY_W = 8,
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [GRAY_W-1:0]   bin,
    output logic                busy,
    output logic                done,
    output logic [DIGITS*4-1:0] bcd,
    output bcd_state_t          state
);

    localparam int BCD_W  = DIGITS * 4;
    localparam int SR_W   = BCD_W + GRAY_W;
    localparam int ITER_W = $clog2(GRAY_W);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(GRAY_W - 1);

    logic [SR_W-1:0]   sr;
    logic [SR_W-1:0]   sr_adj;
    logic [SR_W-1:0]   sr_shift;
    logic [ITER_W-1:0] iter;

    // Add-3 correction on every BCD nibble that would overflow past 9 after the shift.
    always_comb begin
        sr_adj = sr;
        for (int d = 0; d < DIGITS; d++) begin
            if (sr[GRAY_W + 4*d +: 4] >= 4'd5) begin
                sr_adj[GRAY_W + 4*d +: 4] = sr[GRAY_W + 4*d +: 4] + 4'd3;
            end
        end
        sr_shift = {sr_adj[SR_W-2:0], 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sr    <= '0;
            iter  <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sr    <= {{BCD_W{1'b0}}, bin};
                        iter  <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr <= sr_shift;
                    if (iter == ITER_LAST) begin
                        state <= DONE;
                    end else begin
                        iter <= iter + ITER_W'(1);
                    end
                end
                DONE: begin
                    if (start) begin
                        sr    <= {{BCD_W{1'b0}}, bin};
                        iter  <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign done = (state == DONE);
    assign bcd  = sr[SR_W-1 -: BCD_W];

endmodule

// File: rtl/gray_bcd_display_mux.sv
// Gray/binary switch decoder with multiplexed 7-segment decimal display.
//   clk_pi          : system clock
//   rst_pi          : asynchronous active-low reset
//   gray_code_pi    : raw switch word (asynchronous)
//   mode_pi         : 0 = Gray input, 1 = plain binary (asynchronous)
//   lzb_pi          : 1 = blank leading zero digits (quasi-static)
//   anode_po        : one-hot-low digit enables
//   cathode_po      : active-low segments {g,f,e,d,c,b,a}
//   led_bin_code_po : last accepted binary value
//   valid_po        : one-cycle pulse when a new BCD value reaches the display
//   busy_po         : BCD conversion in progress
module gray_bcd_display_mux
    import gray_disp_pkg::*;
#(
    parameter int GRAY_W     = 8,
    parameter int DIGITS     = 3,
    parameter int REFRESH_W  = 16,
    parameter int STABLE_CYC = 4
) (
    input  logic              clk_pi,
    input  logic              rst_pi,
    input  logic [GRAY_W-1:0] gray_code_pi,
    input  logic              mode_pi,
    input  logic              lzb_pi,
    output logic [DIGITS-1:0] anode_po,
    output logic [6:0]        cathode_po,
    output logic [GRAY_W-1:0] led_bin_code_po,
    output logic              valid_po,
    output logic              busy_po
);

    generate
        if (GRAY_W < 2 || GRAY_W > 16) begin : g_bad_gray_w
            $fatal(1, "gray_bcd_display_mux: GRAY_W must be in 2..16");
        end
        if (!digits_fit(GRAY_W, DIGITS)) begin : g_bad_digits
            $fatal(1, "gray_bcd_display_mux: DIGITS too small for GRAY_W");
        end
        if (STABLE_CYC < 1) begin : g_bad_stable
            $fatal(1, "gray_bcd_display_mux: STABLE_CYC must be >= 1");
        end
    endgenerate

    localparam int W     = GRAY_W + 1;   // {mode, code}
    localparam int CNT_W = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    // Input path
    logic [W-1:0]      sync1, sync2, prev_w, last_w;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic              accept;
    logic [GRAY_W-1:0] accept_val;
    logic              accept_q;
    logic              pending;

    // BCD engine
    logic                eng_start, eng_take;
    logic                eng_busy, eng_done;
    logic [DIGITS*4-1:0] eng_bcd;
    bcd_state_t          eng_state;

    // Display
    logic [DIGITS*4-1:0] bcd_disp;
    logic [REFRESH_W-1:0] refresh;
    logic [IDX_W-1:0]    idx;
    logic [DIGITS-1:0]   anode_next;
    logic [6:0]          cathode_next;
    logic [3:0]          cur_nib;
    logic                lead_zero;

    // Acceptance fires on the edge where the run of equal samples reaches
    // STABLE_CYC; the saturated count cannot re-fire because last_w then matches.
    always_comb begin
        cnt_next = '0;
        if (sync2 == prev_w) begin
            cnt_next = (cnt == CNT_LAST) ? cnt : cnt + CNT_W'(1);
        end
        accept     = (cnt_next == CNT_LAST) && (sync2 != last_w);
        accept_val = sync2[GRAY_W] ? sync2[GRAY_W-1:0]
                                   : GRAY_W'(gray2bin(16'(sync2[GRAY_W-1:0]), GRAY_W));
    end

    // A fresh acceptance or a parked one asks for a conversion; only the newest
    // led value matters, so one pending bit is enough.
    assign eng_start = accept_q | pending;
    assign eng_take  = eng_start && (eng_state != SHIFT);

    bin2bcd_seq #(
        .GRAY_W (GRAY_W),
        .DIGITS (DIGITS)
    ) u_bcd (
        .clk   (clk_pi),
        .rst_n (rst_pi),
        .start (eng_start),
        .bin   (led_bin_code_po),
        .busy  (eng_busy),
        .done  (eng_done),
        .bcd   (eng_bcd),
        .state (eng_state)
    );

    always_comb begin
        anode_next = '1;
        cur_nib    = '0;
        lead_zero  = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (idx == IDX_W'(d)) begin
                anode_next[d] = 1'b0;
                cur_nib       = bcd_disp[4*d +: 4];
            end
            if (d >= int'(idx) && bcd_disp[4*d +: 4] != 4'd0) begin
                lead_zero = 1'b0;
            end
        end
        cathode_next = (lzb_pi && idx != '0 && lead_zero) ? SEG_BLANK : seg7(cur_nib);
    end

    always_ff @(posedge clk_pi or negedge rst_pi) begin
        if (!rst_pi) begin
            sync1           <= '0;
            sync2           <= '0;
            prev_w          <= '0;
            cnt             <= '0;
            last_w          <= '0;
            led_bin_code_po <= '0;
            accept_q        <= 1'b0;
            pending         <= 1'b0;
            bcd_disp        <= '0;
            valid_po        <= 1'b0;
            refresh         <= '0;
            idx             <= '0;
            anode_po        <= '1;
            cathode_po      <= SEG_BLANK;
        end else begin
            sync1    <= {mode_pi, gray_code_pi};
            sync2    <= sync1;
            prev_w   <= sync2;
            cnt      <= cnt_next;
            accept_q <= accept;
            if (accept) begin
                last_w          <= sync2;
                led_bin_code_po <= accept_val;
            end
            pending  <= eng_start && !eng_take;
            valid_po <= eng_done;
            if (eng_done) begin
                bcd_disp <= eng_bcd;
            end
            refresh <= refresh + REFRESH_W'(1);
            if (&refresh) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end
            anode_po   <= anode_next;
            cathode_po <= cathode_next;
        end
    end

    assign busy_po = eng_busy;

endmodule

// File: tb/tb_gray_bcd_display_mux.sv
// Testbench for gray_bcd_display_mux: directed scenarios plus randomized
// switch activity, checked against a sample-history model of the input filter
// and a decimal-arithmetic model of the display.
module tb_gray_bcd_display_mux;

    localparam int GRAY_W     = 8;
    localparam int DIGITS     = 3;
    localparam int REFRESH_W  = 4;
    localparam int STABLE_CYC = 4;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [GRAY_W-1:0] gray = '0;
    logic              mode = 1'b0;
    logic              lzb  = 1'b0;
    logic [DIGITS-1:0] anode;
    logic [6:0]        cathode;
    logic [GRAY_W-1:0] led;
    logic              valid;
    logic              busy;

    gray_bcd_display_mux #(
        .GRAY_W     (GRAY_W),
        .DIGITS     (DIGITS),
        .REFRESH_W  (REFRESH_W),
        .STABLE_CYC (STABLE_CYC)
    ) dut (
        .clk_pi          (clk),
        .rst_pi          (rst_n),
        .gray_code_pi    (gray),
        .mode_pi         (mode),
        .lzb_pi          (lzb),
        .anode_po        (anode),
        .cathode_po      (cathode),
        .led_bin_code_po (led),
        .valid_po        (valid),
        .busy_po         (busy)
    );

    // ---------------- scoreboard state ----------------
    int n_checks  = 0;
    int n_errors  = 0;
    int valid_cnt = 0;
    int busy_cnt  = 0;
    logic [6:0] exp_q[$];

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [GRAY_W-1:0] gray_to_bin(input logic [GRAY_W-1:0] g);
        logic [GRAY_W-1:0] b;
        for (int i = 0; i < GRAY_W; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    // Expected pattern of decimal digit d of value v.
    function automatic logic [6:0] exp_seg(input int v, input int d, input logic blank_en);
        int p;
        p = 1;
        for (int k = 0; k < d; k++) p = p * 10;
        if (blank_en && d > 0 && v < p) return 7'b1111111;
        return seg_tab[(v / p) % 10];
    endfunction

    // ---------------- reference model ----------------
    // hist holds the pin word captured at each clock edge. A word is taken on
    // the edge where the STABLE_CYC samples before the newest one agree and the
    // word differs from the last one taken.
    logic [GRAY_W:0]   hist[$];
    logic [GRAY_W:0]   last_exp = '0;
    logic [GRAY_W-1:0] led_exp  = '0;
    logic [GRAY_W:0]   m_w;
    bit                m_same;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist.delete();
            last_exp = '0;
            led_exp  = '0;
        end else begin
            if (hist.size() >= STABLE_CYC + 1) begin
                m_w    = hist[hist.size() - 2];
                m_same = 1'b1;
                for (int j = 2; j <= STABLE_CYC + 1; j++) begin
                    if (hist[hist.size() - j] != m_w) m_same = 1'b0;
                end
                if (m_same && m_w != last_exp) begin
                    last_exp = m_w;
                    led_exp  = m_w[GRAY_W] ? m_w[GRAY_W-1:0] : gray_to_bin(m_w[GRAY_W-1:0]);
                end
            end
            hist.push_back({mode, gray});
            if (hist.size() > 16) void'(hist.pop_front());
        end
    end

    // Per-cycle monitor: led must follow the model every cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid) valid_cnt++;
            if (busy)  busy_cnt++;
            check("led_track", led, led_exp);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic [GRAY_W-1:0] g, input logic m);
        gray = g;
        mode = m;
    endtask

    task automatic wait_valid(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (valid) seen = 1'b1;
        end
    endtask

    task automatic check_display(input int v, input logic blank_en, input string tag);
        bit         found;
        logic [6:0] seg;
        logic [DIGITS-1:0] want;
        for (int d = 0; d < DIGITS; d++) exp_q.push_back(exp_seg(v, d, blank_en));
        for (int d = 0; d < DIGITS; d++) begin
            want  = ~(DIGITS'(1) << d);
            found = 1'b0;
            seg   = '0;
            for (int i = 0; i < 100 && !found; i++) begin
                @(negedge clk);
                if (anode == want) begin
                    found = 1'b1;
                    seg   = cathode;
                end
            end
            check($sformatf("%s_scan%0d", tag, d), 32'(found), 32'd1);
            check($sformatf("%s_d%0d", tag, d), 32'(seg), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_anode"},   32'(anode),   32'(3'b111));
        check({tag, "_cathode"}, 32'(cathode), 32'(7'b1111111));
        check({tag, "_led"},     32'(led),     32'd0);
        check({tag, "_valid"},   32'(valid),   32'd0);
        check({tag, "_busy"},    32'(busy),    32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int  vc, bc;
        bit  ok;

        // 1. reset values, then first digit appears after release
        cycles(3);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 17 && !ok; i++) begin
            @(negedge clk);
            if (anode == 3'b110 && cathode == 7'b1000000) ok = 1'b1;
        end
        check("rst_release_digit0", 32'(ok), 32'd1);

        // 2. Gray 0x80 -> 255, exact latencies
        vc = valid_cnt;
        drive(8'h80, 1'b0);
        cycles(5);
        check("t2_led_before", 32'(led), 32'd0);
        cycles(1);
        check("t2_led_after", 32'(led), 32'hFF);
        cycles(2);
        check("t2_busy_mid", 32'(busy), 32'd1);
        cycles(7);
        check("t2_valid_early", 32'(valid), 32'd0);
        cycles(1);
        check("t2_valid_pulse", 32'(valid), 32'd1);
        cycles(1);
        check("t2_valid_drop", 32'(valid), 32'd0);
        check("t2_busy_drop", 32'(busy), 32'd0);
        check("t2_valid_count", 32'(valid_cnt - vc), 32'd1);
        check_display(255, 1'b0, "t2");

        // 3. short glitch must be rejected
        vc = valid_cnt;
        bc = busy_cnt;
        drive(8'h01, 1'b0);
        cycles(2);
        drive(8'h80, 1'b0);
        cycles(16);
        check("t3_led", 32'(led), 32'hFF);
        check("t3_no_valid", 32'(valid_cnt - vc), 32'd0);
        check("t3_no_busy", 32'(busy_cnt - bc), 32'd0);

        // 4. binary mode, leading-zero blanking on and off
        lzb = 1'b1;
        drive(8'd7, 1'b1);
        wait_valid(30, ok);
        check("t4_valid_seen", 32'(ok), 32'd1);
        check("t4_led", 32'(led), 32'd7);
        check_display(7, 1'b1, "t4_lzb");
        lzb = 1'b0;
        check_display(7, 1'b0, "t4_nolzb");

        // 5. second acceptance during a conversion -> pending restart
        vc = valid_cnt;
        drive(8'h0A, 1'b0);
        cycles(4);
        drive(8'h01, 1'b0);
        cycles(6);
        check("t5_led_second", 32'(led), 32'd1);
        cycles(24);
        check("t5_valid_count", 32'(valid_cnt - vc), 32'd2);
        check("t5_busy_idle", 32'(busy), 32'd0);
        check_display(1, 1'b0, "t5");

        // 6. asynchronous reset in the middle of SHIFT
        drive(8'h33, 1'b0);
        cycles(10);
        check("t6_busy_before", 32'(busy), 32'd1);
        #1 rst_n = 1'b0;
        drive(8'h00, 1'b0);
        #1 check_reset_outputs("t6");
        #1 rst_n = 1'b1;
        vc = valid_cnt;
        bc = busy_cnt;
        cycles(30);
        check("t6_no_valid", 32'(valid_cnt - vc), 32'd0);
        check("t6_no_busy", 32'(busy_cnt - bc), 32'd0);
        check("t6_led", 32'(led), 32'd0);

        // 7. randomized switch activity, settled result checked on the display
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 30; k++) begin
                drive(GRAY_W'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
                lzb = 1'($urandom_range(0, 1));
                cycles($urandom_range(1, 8));
            end
            cycles(60);
            check("rnd_busy_idle", 32'(busy), 32'd0);
            check("rnd_led", 32'(led), 32'(led_exp));
            check_display(int'(led_exp), lzb, $sformatf("rnd%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gray_bcd_display_mux.md
Name: gray_bcd_display_mux

Overview:
Parametrised Gray-code decoder and multi-digit 7-segment display driver. It is the successor to the fixed 4-bit, 2-digit Gray decoder top.
- Synchronises and debounces a GRAY_W-bit input, then converts it Gray->binary, or passes it through in binary mode.
- Converts the binary value to BCD with a sequential double-dabble engine.
- Time-multiplexes DIGITS digits onto shared active-low cathodes, with optional leading-zero blanking.
- Sits directly behind the board switches and in front of the anode/cathode pins and LEDs.

Parameters:
- GRAY_W, 8: input/binary width; legal range 2..16.
- DIGITS, 3: number of display digits; must satisfy 10^DIGITS > 2^GRAY_W-1 (elaboration-time check, fatal error otherwise).
- REFRESH_W, 16: refresh counter width; the digit index advances on every counter wrap.
- STABLE_CYC, 4: number of consecutive equal synchronised samples required before an input is accepted (>=1).

Ports:
- clk_pi, input, 1: system clock.
- rst_pi, input, 1: reset, asynchronous, active-low.
- gray_code_pi, input, GRAY_W: raw switch input (asynchronous to clk_pi).
- mode_pi, input, 1: 0 = input is Gray, 1 = input is plain binary (asynchronous, synchronised).
- lzb_pi, input, 1: 1 = blank leading zero digits (quasi-static, not synchronised).
- anode_po, output, DIGITS: digit enables, one-hot-low.
- cathode_po, output, 7: segments {g,f,e,d,c,b,a}, active-low.
- led_bin_code_po, output, GRAY_W: accepted binary value.
- valid_po, output, 1: one-cycle pulse when a new BCD value is loaded into the display register.
- busy_po, output, 1: high while the BCD engine is converting.

Behaviour:
Reset: rst_pi is asynchronous and active-low. While rst_pi=0:
- Outputs: anode_po = all 1, cathode_po = 7'b1111111, led_bin_code_po = 0, valid_po = 0, busy_po = 0.
- Internal state: sync flops = 0, filter count = 0, bcd_disp = 0, digit index = 0, refresh counter = 0, FSM = IDLE, pending = 0.
- Asserting reset mid-conversion aborts the conversion with no valid pulse.

Input path:
- Two-flop synchroniser on {mode_pi, gray_code_pi}.
- Stability filter: if the synchronised word equals the previous sample, the filter count increments (saturating); otherwise it clears to 0.
- When the count reaches STABLE_CYC-1 and the word differs from the last accepted word, the word is accepted.
- Accepted value = the binary conversion (b[MSB]=g[MSB]; b[i]=b[i+1]^g[i]) if mode=0, or the raw word if mode=1.
- The accepted value is registered into led_bin_code_po on that edge.
- Latency from a pin change to led update: 2 + STABLE_CYC cycles.
- A change of mode alone is also an accepted change.

BCD engine FSM, states IDLE, SHIFT, DONE:
- IDLE: on acceptance, load the shift register with {BCD=0, bin}, set iteration count = 0, go to SHIFT; busy_po=1.
- SHIFT: one iteration per cycle. First add 3 to every BCD nibble >= 5, then shift the whole register left by 1. After GRAY_W iterations go to DONE.
- DONE: copy the BCD nibbles into bcd_disp, pulse valid_po for 1 cycle, drop busy_po.
  - If pending=1: clear pending and restart from SHIFT with the latest led value.
  - Otherwise go to IDLE.
- An acceptance while busy sets pending. Only the newest value is kept; intermediate values are dropped.
- Latency from led update to bcd_disp/valid: GRAY_W + 2 cycles.

Display mux:
- The refresh counter is free-running. When it reaches all ones, the digit index increments, wrapping from DIGITS-1 to 0.
- anode_po and cathode_po are registered, so they lag the index by one cycle.
- anode_po[idx] = 0 and all other anode bits = 1.
- cathode_po = seg(bcd_disp[idx]). Digit codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Any code > 9 gives 1111111.
- Blanking: if lzb_pi=1, idx>0, and every digit from idx up to DIGITS-1 is 0, then cathode_po = 1111111. Digit 0 is never blanked.
- The anode stays active while blanked.

Decomposition:
- Package gray_disp_pkg:
  - state enum {IDLE, SHIFT, DONE};
  - SEG_BLANK = 7'b1111111;
  - function seg7(bcd nibble) returning the active-low pattern;
  - function gray2bin, parametrised by width.
- Sub-module bin2bcd_seq (params GRAY_W, DIGITS):
  - ports: start, bin, busy, done, bcd;
  - contains the FSM and the pending logic is kept outside it.
- The top module holds the synchroniser, stability filter, pending flag and display mux.

Test Plan:
Bench parameters: GRAY_W=8, DIGITS=3, REFRESH_W=4, STABLE_CYC=4, clock period 10 ns.
1. Reset: rst_pi=0 -> anode 3'b111, cathode 1111111, led 0. After release, within 17 cycles anode=3'b110 and cathode=1000000.
2. Gray 8'b10000000 held -> led 8'hFF after 6 cycles. valid pulses 10 cycles later. Digits 0/1/2 show 0010010/0010010/0100100 ("255").
3. Glitch: input changes to 8'h01 for 2 cycles, then returns -> led unchanged, no valid, busy stays 0.
4. mode_pi=1, input 8'd7, lzb_pi=1 -> led 8'd7. Digit0 shows 1111000; digits 1 and 2 show 1111111. With lzb_pi=0 they show 1000000.
5. Gray 8'h0A (binary 12) accepted, then 8'h01 (binary 1) accepted 3 cycles into the conversion -> two valid pulses. Final display "001" (1111001 on digit0).
6. rst_pi pulsed low mid-SHIFT (between clock edges) -> outputs go to reset values immediately. No valid pulse; busy_po=0.
